s1_serial_tx: RTL

- Transmit end of the S1→S2 serial link.
- After reset, when `updown` is 0, reads all eight 18-bit words of register bank RB1 (addresses 0..7, ascending). Each word is serialized as a 21-bit package {address[2:0], data[17:0]} on `sd`, MSB first, framed by `sen` low.
- Asserts `S1_done` after the last package. The S2 receiver shifts `sd` while `sen`=0 and commits a package on `sen`=1.

---
 rtl/s1_serial_tx_if.sv | 15 +
 rtl/s1_serial_tx.sv | 110 +++++++++++
 2 files changed

// File: rtl/s1_serial_tx_if.sv
// RB1 register-bank access bus between the S1 transmitter and RB1.
//   RB1_RW : access type, 1 = read
//   RB1_A  : word address
//   RB1_D  : write data
//   RB1_Q  : read data, valid the cycle after RB1_A changes
// master = transmitter side, slave = register-bank side.
interface s1_serial_tx_if;
  logic        RB1_RW;
  logic [2:0]  RB1_A;
  logic [17:0] RB1_D;
  logic [17:0] RB1_Q;

  modport master (output RB1_RW, output RB1_A, output RB1_D, input RB1_Q);
  modport slave  (input RB1_RW, input RB1_A, input RB1_D, output RB1_Q);
endinterface

// File: rtl/s1_serial_tx.sv
// s1_serial_tx: transmit end of the S1->S2 serial link.
// Reads RB1 words 0..7 and sends each as {addr[2:0], data[17:0]} MSB first
// on sd while sen is low; sen high marks the package boundary.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   updown    : 0 = this block transmits, 1 = stay idle (sampled in IDLE)
//   S1_done   : sticky transfer-complete flag
//   rb1       : RB1 access bus (master side)
//   sen, sd   : serial enable / data, released (z) when not transmitting
//
// state | meaning
// IDLE  | lines released, wait for updown = 0
// READ  | RB1_A = k, RB1 read in flight
// LOAD  | capture {k, RB1_Q} into the shift register
// SHIFT | 21 bits out on sd with sen low
// GAP   | sen high for one cycle so the receiver commits the package
// DONE  | lines released, S1_done set, wait for reset
module s1_serial_tx #(
  parameter int WORDS = 8,
  parameter int PKT_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              updown,
  output logic              S1_done,
  s1_serial_tx_if.master    rb1,
  inout  wire               sen,
  inout  wire               sd
);

  typedef enum logic [2:0] {IDLE, READ, LOAD, SHIFT, GAP, DONE} state_t;

  localparam logic [2:0] K_LAST   = 3'(WORDS - 1);
  localparam logic [4:0] BIT_LAST = 5'(PKT_W - 1);

  state_t             state, state_nxt;
  logic [2:0]         k;
  logic [4:0]         bit_cnt;
  logic [PKT_W-1:0]   shift;
  logic               line_oe, sen_val, sd_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= 3'd0;
      bit_cnt <= 5'd0;
      shift   <= '0;
      S1_done <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          shift   <= {k, rb1.RB1_Q};
          bit_cnt <= 5'd0;
        end
        SHIFT: begin
          shift   <= {shift[PKT_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
        end
        GAP: begin
          // k stops at the last word so RB1_A still shows 7 in DONE
          if (k != K_LAST) k <= k + 3'd1;
        end
        DONE:    S1_done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    line_oe   = 1'b0;
    sen_val   = 1'b1;
    sd_val    = 1'b0;
    case (state)
      IDLE: begin
        if (!updown) state_nxt = READ;
      end
      READ: begin
        line_oe   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        line_oe   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        line_oe = 1'b1;
        sen_val = 1'b0;
        sd_val  = shift[PKT_W-1];
        if (bit_cnt == BIT_LAST) state_nxt = GAP;
      end
      GAP: begin
        line_oe   = 1'b1;
        state_nxt = (k == K_LAST) ? DONE : READ;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // RB1_A is the word counter itself, so it is registered and tracks k
  assign rb1.RB1_A  = k;
  assign rb1.RB1_RW = 1'b1;
  assign rb1.RB1_D  = '0;

  assign sen = line_oe ? sen_val : 1'bz;
  assign sd  = line_oe ? sd_val  : 1'bz;

endmodule
